// File: rtl/bitonic_pkg.sv
// Shared helpers for the bitonic sorter: column count and per-column pairing/direction.
// Optional index tracking is enabled by defining SORT_INDEX_EN.
package bitonic_pkg;

  function automatic int stages(input int log2n);
    return log2n * (log2n + 1) / 2;
  endfunction

  // Column col belongs to merge size 2**s and compares elements 2**t apart.
  function automatic int col_dist(input int log2n, input int col);
    int cnt;
    int d;
    cnt = 0;
    d = 1;
    for (int s = 1; s <= log2n; s++) begin
      for (int t = s - 1; t >= 0; t--) begin
        if (cnt == col) d = 1 << t;
        cnt++;
      end
    end
    return d;
  endfunction

  function automatic logic col_desc(input int log2n, input int col, input int idx);
    int cnt;
    logic r;
    cnt = 0;
    r = 1'b0;
    for (int s = 1; s <= log2n; s++) begin
      for (int t = s - 1; t >= 0; t--) begin
        if (cnt == col) r = ((idx >> s) & 1) != 0;
        cnt++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bitonic_sort_pipe_cmp_swap.sv
// Combinational compare-exchange cell; swaps only on strict disorder, so ties never move.
// With SORT_INDEX_EN the element's original position travels with it.
module cmp_swap
  import bitonic_pkg::*;
#(
  parameter int W      = 8,
  parameter int SIGNED = 0
`ifdef SORT_INDEX_EN
  ,
  parameter int IW     = 1
`endif
) (
  input  logic          desc_i,
  input  logic [W-1:0]  lo_i,
  input  logic [W-1:0]  hi_i,
`ifdef SORT_INDEX_EN
  input  logic [IW-1:0] lo_idx_i,
  input  logic [IW-1:0] hi_idx_i,
  output logic [IW-1:0] lo_idx_o,
  output logic [IW-1:0] hi_idx_o,
`endif
  output logic [W-1:0]  lo_o,
  output logic [W-1:0]  hi_o
);
  typedef logic [W-1:0] elem_t;

  logic lo_gt;
  logic hi_gt;
  logic swap;

  always_comb begin
    lo_gt = 1'b0;
    hi_gt = 1'b0;
    if (SIGNED != 0) begin
      lo_gt = $signed(lo_i) > $signed(hi_i);
      hi_gt = $signed(hi_i) > $signed(lo_i);
    end else begin
      lo_gt = lo_i > hi_i;
      hi_gt = hi_i > lo_i;
    end
    swap = desc_i ? hi_gt : lo_gt;
  end

  assign lo_o = swap ? elem_t'(hi_i) : elem_t'(lo_i);
  assign hi_o = swap ? elem_t'(lo_i) : elem_t'(hi_i);
`ifdef SORT_INDEX_EN
  assign lo_idx_o = swap ? hi_idx_i : lo_idx_i;
  assign hi_idx_o = swap ? lo_idx_i : hi_idx_i;
`endif

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Pipelined bitonic sorter, one register bank per compare column (latency = stages(LOG2N)).
// Single global advance stalls every bank when the output is held; SORT_INDEX_EN adds out_idx.
module bitonic_sort_pipe
  import bitonic_pkg::*;
#(
  parameter int W      = 8,
  parameter int LOG2N  = 3,
  parameter int SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_desc,
  input  logic [(2**LOG2N)*W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(2**LOG2N)*W-1:0]   out_data,
`ifdef SORT_INDEX_EN
  output logic [(2**LOG2N)*LOG2N-1:0] out_idx,
`endif
  output logic                      out_desc
);
  localparam int N  = 2 ** LOG2N;
  localparam int ST = stages(LOG2N);

  typedef logic [W-1:0]     elem_t;
  typedef logic [LOG2N-1:0] idx_t;

  elem_t col_in [ST][N];
  elem_t dat_d  [ST][N];
  elem_t dat_q  [ST][N];
  logic  col_dsc[ST];
  logic  vld_q  [ST];
  logic  desc_q [ST];
  logic  adv;

  assign adv       = !vld_q[ST-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[ST-1];
  assign out_desc  = desc_q[ST-1];

`ifdef SORT_INDEX_EN
  idx_t idx_in[ST][N];
  idx_t idx_d [ST][N];
  idx_t idx_q [ST][N];
`endif

  for (genvar c = 0; c < ST; c++) begin : g_col
    if (c == 0) begin : g_first
      assign col_dsc[c] = in_desc;
      for (genvar i = 0; i < N; i++) begin : g_in
        assign col_in[c][i] = in_data[i*W +: W];
`ifdef SORT_INDEX_EN
        assign idx_in[c][i] = idx_t'(i);
`endif
      end
    end else begin : g_rest
      assign col_dsc[c] = desc_q[c-1];
      for (genvar i = 0; i < N; i++) begin : g_in
        assign col_in[c][i] = dat_q[c-1][i];
`ifdef SORT_INDEX_EN
        assign idx_in[c][i] = idx_q[c-1][i];
`endif
      end
    end

    for (genvar p = 0; p < N / 2; p++) begin : g_cell
      localparam int   D  = col_dist(LOG2N, c);
      localparam int   LO = (p / D) * 2 * D + (p % D);
      localparam int   HI = LO + D;
      localparam logic CD = col_desc(LOG2N, c, LO);

      cmp_swap #(
        .W      (W),
        .SIGNED (SIGNED)
`ifdef SORT_INDEX_EN
        ,
        .IW     (LOG2N)
`endif
      ) u_cs (
        .desc_i   (CD ^ col_dsc[c]),
        .lo_i     (col_in[c][LO]),
        .hi_i     (col_in[c][HI]),
`ifdef SORT_INDEX_EN
        .lo_idx_i (idx_in[c][LO]),
        .hi_idx_i (idx_in[c][HI]),
        .lo_idx_o (idx_d[c][LO]),
        .hi_idx_o (idx_d[c][HI]),
`endif
        .lo_o     (dat_d[c][LO]),
        .hi_o     (dat_d[c][HI])
      );
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_out
    assign out_data[i*W +: W] = dat_q[ST-1][i];
`ifdef SORT_INDEX_EN
    assign out_idx[i*LOG2N +: LOG2N] = idx_q[ST-1][i];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < ST; c++) begin
        vld_q[c]  <= 1'b0;
        desc_q[c] <= 1'b0;
        for (int i = 0; i < N; i++) begin
          dat_q[c][i] <= '0;
`ifdef SORT_INDEX_EN
          idx_q[c][i] <= '0;
`endif
        end
      end
    end else if (adv) begin
      vld_q[0]  <= in_valid;
      desc_q[0] <= in_desc;
      for (int c = 1; c < ST; c++) begin
        vld_q[c]  <= vld_q[c-1];
        desc_q[c] <= desc_q[c-1];
      end
      for (int c = 0; c < ST; c++) begin
        for (int i = 0; i < N; i++) begin
          dat_q[c][i] <= dat_d[c][i];
`ifdef SORT_INDEX_EN
          idx_q[c][i] <= idx_d[c][i];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Bench for bitonic_sort_pipe: unsigned and signed 8x8 instances share stimulus; a sorting
// model feeds per-instance scoreboards checked every output cycle, plus literal directed checks.
module tb_bitonic_sort_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_desc;
  logic [63:0] in_data;
  logic        out_ready;

  logic        in_ready_u, out_valid_u, out_desc_u;
  logic [63:0] out_data_u;
  logic        in_ready_s, out_valid_s, out_desc_s;
  logic [63:0] out_data_s;
`ifdef SORT_INDEX_EN
  logic [23:0] out_idx_u;
  logic [23:0] out_idx_s;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop_u = 0;

  typedef struct {
    logic [63:0] d;
    logic        desc;
  } exp_t;

  exp_t q_u[$];
  exp_t q_s[$];

  bitonic_sort_pipe #(.W(8), .LOG2N(3), .SIGNED(0)) u_dut_u (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_u),
    .in_desc   (in_desc),
    .in_data   (in_data),
    .out_valid (out_valid_u),
    .out_ready (out_ready),
    .out_data  (out_data_u),
`ifdef SORT_INDEX_EN
    .out_idx   (out_idx_u),
`endif
    .out_desc  (out_desc_u)
  );

  bitonic_sort_pipe #(.W(8), .LOG2N(3), .SIGNED(1)) u_dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_desc   (in_desc),
    .in_data   (in_data),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_data  (out_data_s),
`ifdef SORT_INDEX_EN
    .out_idx   (out_idx_s),
`endif
    .out_desc  (out_desc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pk8(input logic [7:0] e0, input logic [7:0] e1,
                                      input logic [7:0] e2, input logic [7:0] e3,
                                      input logic [7:0] e4, input logic [7:0] e5,
                                      input logic [7:0] e6, input logic [7:0] e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  // Reference: plain sort of the eight values, reversed for descending.
  function automatic logic [63:0] ref_sort(input logic [63:0] d, input logic desc, input logic sgn);
    int v[8];
    int t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++)
      v[i] = sgn ? int'($signed(d[i*8 +: 8])) : int'({24'd0, d[i*8 +: 8]});
    for (int a = 0; a < 7; a++)
      for (int b = 0; b < 7 - a; b++)
        if (v[b] > v[b+1]) begin
          t = v[b]; v[b] = v[b+1]; v[b+1] = t;
        end
    r = '0;
    for (int i = 0; i < 8; i++) begin
      t = desc ? v[7-i] : v[i];
      r[i*8 +: 8] = t[7:0];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected handshake", nm);
  endtask

  // Scoreboard compare at the falling edge; pushes/pops mirror the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q_u.delete();
      q_s.delete();
      chk("rst_out_valid_u", 64'(out_valid_u), 64'd0);
    end else begin
      if (out_valid_u) begin
        if (q_u.size() == 0) fail_now("stale_u");
        else begin
          chk("mon_u_data", out_data_u, q_u[0].d);
          chk("mon_u_desc", 64'(out_desc_u), 64'(q_u[0].desc));
          if (out_ready) begin void'(q_u.pop_front()); n_pop_u++; end
        end
      end
      if (out_valid_s) begin
        if (q_s.size() == 0) fail_now("stale_s");
        else begin
          chk("mon_s_data", out_data_s, q_s[0].d);
          chk("mon_s_desc", 64'(out_desc_s), 64'(q_s[0].desc));
          if (out_ready) void'(q_s.pop_front());
        end
      end
      if (in_valid && in_ready_u) begin
        e.desc = in_desc;
        e.d = ref_sort(in_data, in_desc, 1'b0);
        q_u.push_back(e);
        e.d = ref_sort(in_data, in_desc, 1'b1);
        q_s.push_back(e);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [63:0] d, input logic desc, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_data = d;
    in_desc = desc;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = in_ready_u;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) fail_now("send_accept");
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q_u.size() != 0 || q_s.size() != 0) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_empty", 64'(q_u.size() + q_s.size()), 64'd0);
  endtask

  initial begin
    int w;
    int total;
    int pops0;
    logic [63:0] vec;

    rst = 1'b1;
    in_valid = 1'b0;
    in_desc = 1'b0;
    in_data = '0;
    out_ready = 1'b1;

    chk("model_asc", ref_sort(pk8(5,3,200,0,255,7,7,1), 1'b0, 1'b0), pk8(0,1,3,5,7,7,200,255));
    chk("model_sgn", ref_sort(pk8(8'h80,8'h7F,8'hFF,8'h00,8'h01,8'hFE,8'h10,8'h81), 1'b0, 1'b1),
        pk8(8'h80,8'h81,8'hFE,8'hFF,8'h00,8'h01,8'h10,8'h7F));

    wait_cycles(3);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 64'(in_ready_u), 64'd1);
    chk("reset_out_valid", 64'(out_valid_u), 64'd0);
    chk("reset_out_data", out_data_u, 64'd0);
    chk("reset_out_desc", 64'(out_desc_u), 64'd0);
    chk("reset_out_data_s", out_data_s, 64'd0);
    wait_cycles(1);

    // Latency and ascending literal.
    send(pk8(5,3,200,0,255,7,7,1), 1'b0, w);
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("latency_vld_%0d", k), 64'(out_valid_u), 64'(k == 5));
    end
    chk("asc_data", out_data_u, pk8(0,1,3,5,7,7,200,255));
    chk("asc_desc", 64'(out_desc_u), 64'd0);
    wait_cycles(1);

    // Descending literal.
    send(pk8(5,3,200,0,255,7,7,1), 1'b1, w);
    in_valid = 1'b0;
    wait_cycles(5);
    chk("desc_vld", 64'(out_valid_u), 64'd1);
    chk("desc_data", out_data_u, pk8(255,200,7,7,5,3,1,0));
    chk("desc_flag", 64'(out_desc_u), 64'd1);
    wait_cycles(1);

    // Signed literal.
    send(pk8(8'h80,8'h7F,8'hFF,8'h00,8'h01,8'hFE,8'h10,8'h81), 1'b0, w);
    in_valid = 1'b0;
    wait_cycles(5);
    chk("signed_vld", 64'(out_valid_s), 64'd1);
    chk("signed_data", out_data_s, pk8(8'h80,8'h81,8'hFE,8'hFF,8'h00,8'h01,8'h10,8'h7F));
    wait_cycles(1);

`ifdef SORT_INDEX_EN
    send(pk8(9,8,7,6,5,4,3,2), 1'b0, w);
    in_valid = 1'b0;
    wait_cycles(5);
    chk("idx_data", out_data_u, pk8(2,3,4,5,6,7,8,9));
    chk("idx_slots", 64'(out_idx_u), 64'({3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7}));
    wait_cycles(1);
`endif

    // 20 back-to-back random vectors.
    total = 0;
    pops0 = n_pop_u;
    for (int n = 0; n < 20; n++) begin
      vec = {$urandom, $urandom};
      send(vec, 1'($urandom_range(0, 1)), w);
      total += w;
    end
    in_valid = 1'b0;
    chk("burst_cycles", 64'(total), 64'd20);
    drain();
    chk("burst_pops", 64'(n_pop_u - pops0), 64'd20);

    // Stall with a full pipe.
    out_ready = 1'b0;
    total = 0;
    for (int n = 0; n < 6; n++) begin
      send({$urandom, $urandom}, 1'(n & 1), w);
      total += w;
    end
    chk("fill_cycles", 64'(total), 64'd6);
    vec = {$urandom, $urandom};
    in_valid = 1'b1;
    in_data = vec;
    in_desc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("stall_in_ready_%0d", k), 64'(in_ready_u), 64'd0);
      chk($sformatf("stall_out_valid_%0d", k), 64'(out_valid_u), 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    pops0 = n_pop_u;
    send(vec, 1'b0, w);
    in_valid = 1'b0;
    drain();
    chk("stall_pops", 64'(n_pop_u - pops0), 64'd7);

    // Reset with three vectors in flight.
    for (int n = 0; n < 3; n++) send({$urandom, $urandom}, 1'b0, w);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid_u), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_quiet_%0d", k), 64'(out_valid_u | out_valid_s), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
